// File: rtl/ma_sample_sequencer.sv
// Sequencer between a valid/ready sample stream and the moving-average filter datapath.
// Latency: push at t -> strobe at t+2 -> filter done at t+3+N -> out_valid from t+5+N.
// Backpressure: a held result blocks new issues, which then fills the 2-deep input FIFO (in_ready=0).
//
// Ports:
//   clk, reset                     : rising-edge clock, asynchronous active-high reset
//   in_data/in_valid/in_ready      : upstream sample stream (in_ready = FIFO not full)
//   flt_data/flt_strobe            : registered sample and one-cycle strobe to the filter
//   flt_done/flt_result            : filter completion strobe and average
//   out_data/out_valid/out_ready   : downstream result stream
//   cfg_decim                      : forward one of every cfg_decim+1 results
//   clr_err/err                    : sticky watchdog flag and its clear
//   busy                           : sequencer not in IDLE
module ma_sample_sequencer #(
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] flt_data,
  output logic              flt_strobe,
  input  logic              flt_done,
  input  logic [DATA_W-1:0] flt_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [3:0]        cfg_decim,
  input  logic              clr_err,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    CAPTURE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // ------------------------------------------------------------------
  // Two-entry input FIFO. Pointers are single bits because the depth is
  // two; simultaneous push and pop leave the count unchanged.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wr_ptr;
  logic              fifo_rd_ptr;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  assign fifo_full  = (fifo_count == 2'd2);
  assign fifo_empty = (fifo_count == 2'd0);
  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_head  = fifo_mem[fifo_rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fifo_push) fifo_wr_ptr <= !fifo_wr_ptr;
      if (fifo_pop)  fifo_rd_ptr <= !fifo_rd_ptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  logic [TW-1:0] timer;
  logic [3:0]    dec_cnt;
  logic          issue;
  logic          timer_clr;
  logic          timer_inc;
  logic          err_set;
  logic          capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    issue     = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    err_set   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // A held result blocks issue so the filter never overwrites it.
        if (!fifo_empty && !out_valid) begin
          fifo_pop  = 1'b1;
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (flt_done) begin
          state_nxt = CAPTURE;
        end else if (timer == TIMER_LAST) begin
          // Filter never finished: drop this sample, flag it, move on.
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_data   <= '0;
      flt_strobe <= 1'b0;
      timer      <= '0;
      err        <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      dec_cnt    <= '0;
    end else begin
      // Strobe is the registered issue decision, so it is high only in ISSUE.
      flt_strobe <= issue;
      if (issue) flt_data <= fifo_head;

      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;

      // A watchdog hit takes priority over a coincident clear.
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;

      if (capture) begin
        // >= so that lowering cfg_decim below the running count forwards at once.
        if (dec_cnt >= cfg_decim) begin
          out_data  <= flt_result;
          out_valid <= 1'b1;
          dec_cnt   <= '0;
        end else begin
          dec_cnt <= dec_cnt + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ma_sample_sequencer.sv
// Directed testbench for ma_sample_sequencer with a behavioural N=4 moving-average filter.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task performs its own comparisons; one summary line at the end.
module tb_ma_sample_sequencer;

  localparam int DATA_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] flt_data;
  logic              flt_strobe;
  logic              flt_done;
  logic [DATA_W-1:0] flt_result;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        cfg_decim;
  logic              clr_err;
  logic              busy;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;

  logic hang;
  logic spur_done;
  logic model_done;

  assign flt_done = model_done | spur_done;

  ma_sample_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flt_data   (flt_data),
    .flt_strobe (flt_strobe),
    .flt_done   (flt_done),
    .flt_result (flt_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_decim  (cfg_decim),
    .clr_err    (clr_err),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural filter, FILTER_SIZE=4: done one cycle after N counting cycles.
  logic [DATA_W-1:0] hist [4];
  logic [DATA_W-1:0] pend;
  int                mcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0; hist[3] <= '0;
      pend <= '0; mcnt <= 0; model_done <= 1'b0; flt_result <= '0;
    end else begin
      model_done <= 1'b0;
      if (flt_strobe) begin
        hist[0] <= flt_data; hist[1] <= hist[0]; hist[2] <= hist[1]; hist[3] <= hist[2];
        pend <= 10'((12'(flt_data) + 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2])) >> 2);
        mcnt <= 4;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !hang) begin
          model_done <= 1'b1;
          flt_result <= pend;
        end
      end
    end
  end

  always @(negedge clk) if (flt_strobe) strobe_cnt <= strobe_cnt + 1;

  // Push one sample, waiting (bounded) for in_ready. Returns on the falling edge after acceptance.
  task automatic push(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL push_accept: in_ready=%b for data %h, required 1 within 200 cycles", in_ready, d);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (flt_data !== '0)     begin miscompares++; $display("FAIL reset_flt_data: got %h want 000", flt_data); end
    vectors++; if (flt_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_flt_strobe: got %b want 0", flt_strobe); end
    vectors++; if (out_data !== '0)     begin miscompares++; $display("FAIL reset_out_data: got %h want 000", out_data); end
    vectors++; if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle: busy=%b in_ready=%b want 0/1", busy, in_ready); end
  endtask

  task automatic test_single_sample;
    int first_vld, data_bad, s0;
    first_vld = -1; data_bad = 0; s0 = strobe_cnt;
    @(negedge clk);
    in_data  = 10'h100;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (i >= 2 && i <= 7 && flt_data !== 10'h100) data_bad++;
      if (i == 2) begin
        vectors++; if (flt_strobe !== 1'b1) begin miscompares++; $display("FAIL single_strobe_t2: got %b want 1", flt_strobe); end
      end
      if (i == 7) begin
        vectors++; if (flt_done !== 1'b1) begin miscompares++; $display("FAIL single_done_t7: got %b want 1", flt_done); end
      end
      if (out_valid === 1'b1 && first_vld < 0) first_vld = i;
    end
    vectors++; if (strobe_cnt - s0 != 1) begin miscompares++; $display("FAIL single_strobe_count: got %0d want 1", strobe_cnt - s0); end
    vectors++; if (data_bad != 0)        begin miscompares++; $display("FAIL single_flt_data_hold: %0d cycles not 100, want 0", data_bad); end
    vectors++; if (first_vld != 9)       begin miscompares++; $display("FAIL single_latency: out_valid first at +%0d want +9", first_vld); end
    vectors++; if (out_data !== 10'h040) begin miscompares++; $display("FAIL single_result: got %h want 040", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_consume: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_pressure;
    logic [DATA_W-1:0] got [4];
    logic [DATA_W-1:0] exp_res [4];
    int ng, n, s0;
    exp_res[0] = 10'h044; exp_res[1] = 10'h04C; exp_res[2] = 10'h058; exp_res[3] = 10'h028;
    ng = 0;
    out_ready = 1'b0;
    push(10'h010);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    vectors++; if (out_valid !== 1'b1 || out_data !== 10'h044) begin miscompares++; $display("FAIL bp_first_result: valid=%b data=%h want 1/044", out_valid, out_data); end
    s0 = strobe_cnt;
    push(10'h020);
    push(10'h030);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    repeat (20) @(negedge clk);
    vectors++; if (strobe_cnt != s0) begin miscompares++; $display("FAIL bp_no_strobe: %0d extra strobes want 0", strobe_cnt - s0); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 10'h044) begin miscompares++; $display("FAIL bp_held: valid=%b data=%h want 1/044", out_valid, out_data); end
    fork
      push(10'h040);
      begin
        out_ready = 1'b1;
        for (int c = 0; c < 200 && ng < 4; c++) begin
          if (out_valid === 1'b1) begin got[ng] = out_data; ng++; end
          @(negedge clk);
        end
      end
    join
    vectors++; if (ng != 4) begin miscompares++; $display("FAIL bp_result_count: got %0d want 4", ng); end
    for (int k = 0; k < ng; k++) begin
      vectors++;
      if (got[k] !== exp_res[k]) begin miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], exp_res[k]); end
    end
  endtask

  task automatic test_decimation;
    logic [DATA_W-1:0] got [6];
    logic [DATA_W-1:0] samples [6];
    int ng;
    samples[0] = 10'h100; samples[1] = 10'h100; samples[2] = 10'h100;
    samples[3] = 10'h100; samples[4] = 10'h200; samples[5] = 10'h200;
    ng = 0;
    @(negedge clk);
    cfg_decim = 4'd2;
    out_ready = 1'b1;
    fork
      for (int k = 0; k < 6; k++) push(samples[k]);
      for (int c = 0; c < 150; c++) begin
        if (out_valid === 1'b1 && ng < 6) begin got[ng] = out_data; ng++; end
        @(negedge clk);
      end
    join
    vectors++; if (ng != 2) begin miscompares++; $display("FAIL decim_count: got %0d results want 2", ng); end
    if (ng >= 2) begin
      vectors++; if (got[0] !== 10'h0D0) begin miscompares++; $display("FAIL decim_third: got %h want 0d0", got[0]); end
      vectors++; if (got[1] !== 10'h180) begin miscompares++; $display("FAIL decim_sixth: got %h want 180", got[1]); end
    end
    vectors++; if (dut.dec_cnt !== 4'd0) begin miscompares++; $display("FAIL decim_dec_cnt: got %0d want 0", dut.dec_cnt); end
  endtask

  task automatic test_spurious_done;
    int n;
    hang = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL spur_pre_idle: busy=%b want 0", busy); end
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL spur_idle: busy=%b out_valid=%b want 0/0", busy, out_valid); end
    vectors++; if (dut.dec_cnt !== 4'd0) begin miscompares++; $display("FAIL spur_idle_dec_cnt: got %0d want 0", dut.dec_cnt); end
    push(10'h055);
    n = 0;
    while (!flt_strobe && n < 20) begin @(negedge clk); n++; end
    vectors++; if (flt_strobe !== 1'b1) begin miscompares++; $display("FAIL spur_issue_seen: flt_strobe=%b want 1", flt_strobe); end
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (25) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL spur_issue_out_valid: got %b want 0", out_valid); end
    vectors++; if (dut.dec_cnt !== 4'd0) begin miscompares++; $display("FAIL spur_issue_dec_cnt: got %0d want 0", dut.dec_cnt); end
    vectors++; if (err !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL spur_issue_timeout: err=%b busy=%b want 1/0", err, busy); end
  endtask

  task automatic test_timeout;
    hang = 1'b1;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_clr: err=%b want 0", err); end
    @(negedge clk);
    in_data  = 10'h0A1;
    in_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      case (i)
        1: in_data = 10'h0B2;
        2: begin
          in_valid = 1'b0;
          vectors++; if (flt_strobe !== 1'b1 || flt_data !== 10'h0A1) begin miscompares++; $display("FAIL to_issue_a: strobe=%b data=%h want 1/0a1", flt_strobe, flt_data); end
        end
        18: begin
          vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_early: err=%b want 0", err); end
        end
        19: begin
          vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err_fire: err=%b want 1", err); end
          vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_back_idle: busy=%b want 0", busy); end
        end
        20: begin
          vectors++; if (flt_strobe !== 1'b1 || flt_data !== 10'h0B2) begin miscompares++; $display("FAIL to_next_issue: strobe=%b data=%h want 1/0b2", flt_strobe, flt_data); end
        end
        22: clr_err = 1'b1;
        23: clr_err = 1'b0;
        25: begin
          vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_clr_pulse: err=%b want 0", err); end
        end
        36: begin
          vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_early_b: err=%b want 0", err); end
          clr_err = 1'b1;
        end
        37: begin
          clr_err = 1'b0;
          vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_set_wins: err=%b want 1", err); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid_op;
    int s0, saw_vld;
    hang = 1'b1;
    @(negedge clk);
    in_data  = 10'h111;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      case (i)
        1: in_data = 10'h222;
        2: in_data = 10'h333;
        3: begin
          in_valid = 1'b0;
          vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_fifo_full: in_ready=%b want 0", in_ready); end
        end
        4: begin
          vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_in_wait: busy=%b want 1", busy); end
        end
        default: ;
      endcase
    end
    #2 reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_async_in_ready: got %b want 1", in_ready); end
    vectors++; if (flt_data !== '0)     begin miscompares++; $display("FAIL rst_async_flt_data: got %h want 000", flt_data); end
    vectors++; if (out_data !== '0)     begin miscompares++; $display("FAIL rst_async_out_data: got %h want 000", out_data); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL rst_async_err: got %b want 0", err); end
    vectors++; if (out_valid !== 1'b0 || flt_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid_strobe: %b/%b want 0/0", out_valid, flt_strobe); end
    @(negedge clk);
    reset = 1'b0;
    hang  = 1'b0;
    s0 = strobe_cnt;
    saw_vld = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_vld++;
    end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    vectors++; if (saw_vld != 0)      begin miscompares++; $display("FAIL rst_release_out_valid: %0d cycles high want 0", saw_vld); end
    vectors++; if (strobe_cnt != s0)  begin miscompares++; $display("FAIL rst_release_strobe: %0d strobes want 0", strobe_cnt - s0); end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cfg_decim = 4'd0;
    clr_err   = 1'b0;
    hang      = 1'b0;
    spur_done = 1'b0;
    test_reset();
    test_single_sample();
    test_back_pressure();
    test_decimation();
    test_spurious_done();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded 30000 cycles, required completion");
    $fatal(1, "global timeout");
  end

endmodule
